// File: rtl/async_evt_pkg.sv
// Shared types and constants for the asynchronous input event arbiter.
package async_evt_pkg;

  typedef enum logic {INIT, RUN}  top_state_t;
  typedef enum logic {IDLE, HOLD} arb_state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned INIT_CYCLES = 3;
  localparam int unsigned TS_W        = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_synchroniser.sv
// Per-line two-flop synchroniser for asynchronous pin inputs; no reset on the sync flops.
module input_synchroniser
  import async_evt_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_line
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sh;

    always_ff @(posedge i_clk) begin
      r_sh <= {r_sh[SYNC_STAGES-2:0], i_d[g]};
    end

    assign o_q[g] = r_sh[SYNC_STAGES-1];
  end

endmodule

// File: rtl/async_input_event_arbiter.sv
// Synchronise, debounce and round-robin report asynchronous status lines on one event stream.
// Optional ASYNC_EVT_TIMESTAMP_EN adds a 32-bit commit timestamp to each event.
module async_input_event_arbiter
  import async_evt_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS     = 8,
  parameter  int unsigned DEBOUNCE_COUNT = 1000,
  localparam int unsigned IDX_W          = clog2_min1(NUM_INPUTS),
`ifdef ASYNC_EVT_TIMESTAMP_EN
  localparam int unsigned DATA_W         = IDX_W + 1 + TS_W
`else
  localparam int unsigned DATA_W         = IDX_W + 1
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_INPUTS-1:0] din,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic                  ev_tvalid,
  input  logic                  ev_tready,
  output logic [DATA_W-1:0]     ev_tdata,
  output logic [NUM_INPUTS-1:0] overflow,
  input  logic                  ovf_clear
);

  localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_COUNT);

  top_state_t              r_top;
  arb_state_t              r_arb;
  logic [1:0]              r_init_cnt;
  logic [NUM_INPUTS-1:0]   r_level;
  logic [NUM_INPUTS-1:0]   r_pend;
  logic [NUM_INPUTS-1:0]   r_ovf;
  logic [CNT_W-1:0]        r_cnt [NUM_INPUTS];
  logic [IDX_W-1:0]        r_ptr;
  logic                    r_tvalid;
  logic [DATA_W-1:0]       r_tdata;

  logic [NUM_INPUTS-1:0]   w_sync;
  logic [NUM_INPUTS-1:0]   w_diff;
  logic [NUM_INPUTS-1:0]   w_commit;
  logic [NUM_INPUTS-1:0]   w_gnt_mask;
  logic [IDX_W:0]          w_sum;
  logic [IDX_W-1:0]        w_cand;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic [IDX_W-1:0]        w_ptr_next;
  logic                    w_found;
  logic                    w_grant_en;
  logic [DATA_W-1:0]       w_beat;

  input_synchroniser #(.WIDTH(NUM_INPUTS)) u_sync (
    .i_clk (aclk),
    .i_d   (din),
    .o_q   (w_sync)
  );

  assign level_out = r_level;
  assign ev_tvalid = r_tvalid;
  assign ev_tdata  = r_tdata;
  assign overflow  = r_ovf;

  always_comb begin
    w_diff   = w_sync ^ r_level;
    w_commit = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      w_commit[i] = (r_top == RUN) && w_diff[i] && (r_cnt[i] == CNT_W'(DEBOUNCE_COUNT - 1));
    end
  end

  // Round-robin search: first pending line at or after the pointer, wrapping modulo NUM_INPUTS.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_INPUTS)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_INPUTS);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && r_pend[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_grant_en = w_found && ((r_arb == IDLE) || (r_tvalid && ev_tready));
  assign w_gnt_mask = w_grant_en ? (NUM_INPUTS'(1) << w_gnt_idx) : '0;
  assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;

`ifdef ASYNC_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_ts [NUM_INPUTS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ts_cnt <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) r_ts[i] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (w_commit[i]) r_ts[i] <= r_ts_cnt;
      end
    end
  end

  assign w_beat = {r_ts[w_gnt_idx], r_level[w_gnt_idx], w_gnt_idx};
`else
  assign w_beat = {r_level[w_gnt_idx], w_gnt_idx};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_top      <= INIT;
      r_init_cnt <= '0;
      r_level    <= '0;
    end else if (r_top == INIT) begin
      if (r_init_cnt == 2'(INIT_CYCLES - 1)) begin
        r_level <= w_sync;
        r_top   <= RUN;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end else begin
      r_level <= (r_level & ~w_commit) | (w_sync & w_commit);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) r_cnt[i] <= '0;
    end else if (r_top == RUN) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (!w_diff[i] || w_commit[i]) r_cnt[i] <= '0;
        else                           r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // A commit on the line being granted re-arms pending without counting as overflow.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_mask) | w_commit;
      r_ovf  <= (ovf_clear ? '0 : r_ovf) | (w_commit & r_pend & ~w_gnt_mask);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arb    <= IDLE;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_ptr    <= '0;
    end else if (w_grant_en) begin
      r_tdata  <= w_beat;
      r_tvalid <= 1'b1;
      r_ptr    <= w_ptr_next;
      r_arb    <= HOLD;
    end else if ((r_arb == HOLD) && ev_tready) begin
      r_tvalid <= 1'b0;
      r_arb    <= IDLE;
    end
  end

endmodule

// File: tb/tb_async_input_event_arbiter.sv
// Scoreboard bench for async_input_event_arbiter with NUM_INPUTS=4, DEBOUNCE_COUNT=4.
module tb_async_input_event_arbiter;

`ifdef ASYNC_EVT_TIMESTAMP_EN
  localparam int DW = 35;
`else
  localparam int DW = 3;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [3:0]    din;
  logic [3:0]    level_out;
  logic          ev_tvalid;
  logic          ev_tready;
  logic [DW-1:0] ev_tdata;
  logic [3:0]    overflow;
  logic          ovf_clear;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];

  always #5 aclk = ~aclk;

  async_input_event_arbiter #(.NUM_INPUTS(4), .DEBOUNCE_COUNT(4)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .din       (din),
    .level_out (level_out),
    .ev_tvalid (ev_tvalid),
    .ev_tready (ev_tready),
    .ev_tdata  (ev_tdata),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge aclk) begin
    if (aresetn && ev_tvalid && ev_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected none", ev_tdata[2:0]);
      end else begin
        chk("beat", 32'(ev_tdata[2:0]), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    aresetn = 1'b0; din = 4'b0101; ev_tready = 1'b1; ovf_clear = 1'b0;
    tick(5);
    chk("rst_level",  32'(level_out), 32'h0);
    chk("rst_tvalid", 32'(ev_tvalid), 32'h0);
    chk("rst_tdata",  32'(ev_tdata[2:0]), 32'h0);
    chk("rst_ovf",    32'(overflow),  32'h0);
    aresetn = 1'b1;
    tick(2);
    chk("init_hold",  32'(level_out), 32'h0);
    tick(1);
    chk("init_load",  32'(level_out), 32'h5);
    chk("init_tvalid", 32'(ev_tvalid), 32'h0);
    chk("init_ovf",   32'(overflow),  32'h0);
    tick(10);
    chk("init_no_event", 32'(ev_tvalid), 32'h0);

    // Lines 0 and 2 fall together: granted 0 then 2 from pointer 0.
    din = 4'b0000;
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b010);
    tick(12);
    chk("fall_level", 32'(level_out), 32'h0);

    // Line 2 rises: level at the 6th edge, tvalid one edge later.
    din = 4'b0100;
    exp_q.push_back(3'b110);
    tick(5);
    chk("lat_before", 32'(level_out), 32'h0);
    tick(1);
    chk("lat_at",     32'(level_out), 32'h4);
    chk("pend_no_valid_yet", 32'(ev_tvalid), 32'h0);
    tick(1);
    chk("pend_to_valid", 32'(ev_tvalid), 32'h1);
    tick(3);
    chk("single_beat_done", 32'(ev_tvalid), 32'h0);

    // Three-cycle glitch on line 1 is rejected.
    din = 4'b0110;
    tick(3);
    din = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_level", 32'(level_out), 32'h4);
    end
    chk("glitch_tvalid", 32'(ev_tvalid), 32'h0);

    // Fresh reset so the pointer starts at 0; lines 0 and 3 rise together under backpressure.
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(3);
    chk("reinit_level", 32'(level_out), 32'h4);
    ev_tready = 1'b0;
    din = 4'b1101;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b111);
    tick(6);
    chk("pair_not_yet", 32'(ev_tvalid), 32'h0);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(ev_tvalid), 32'h1);
      chk("hold_data",  32'(ev_tdata[2:0]), 32'h4);
      tick(1);
    end
    ev_tready = 1'b1;
    tick(1);
    chk("b2b_valid", 32'(ev_tvalid), 32'h1);
    chk("b2b_data",  32'(ev_tdata[2:0]), 32'h7);
    tick(1);
    chk("b2b_done",  32'(ev_tvalid), 32'h0);
    din = 4'b0100;
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b011);
    tick(12);

    // Line 1 toggles twice while line 3's event blocks the channel.
    ev_tready = 1'b0;
    din = 4'b1100;
    exp_q.push_back(3'b111);
    tick(8);
    din = 4'b1110;
    tick(8);
    chk("ovf_not_yet", 32'(overflow), 32'h0);
    din = 4'b1100;
    tick(8);
    chk("ovf_set",   32'(overflow),  32'h2);
    chk("ovf_level", 32'(level_out), 32'hC);
    exp_q.push_back(3'b001);
    ev_tready = 1'b1;
    tick(4);
    chk("ovf_drained", 32'(ev_tvalid), 32'h0);
    chk("ovf_sticky",  32'(overflow),  32'h2);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'h0);

    // Reset while an event is held: it is dropped, not replayed.
    ev_tready = 1'b0;
    din = 4'b1000;
    tick(8);
    chk("pre_rst_valid", 32'(ev_tvalid), 32'h1);
    chk("pre_rst_data",  32'(ev_tdata[2:0]), 32'h2);
    aresetn = 1'b0;
    #2;
    chk("midrst_tvalid", 32'(ev_tvalid), 32'h0);
    chk("midrst_tdata",  32'(ev_tdata[2:0]), 32'h0);
    chk("midrst_level",  32'(level_out), 32'h0);
    chk("midrst_ovf",    32'(overflow),  32'h0);
    tick(2);
    aresetn = 1'b1;
    ev_tready = 1'b1;
    tick(3);
    chk("postrst_level", 32'(level_out), 32'h8);
    tick(15);
    chk("postrst_no_event", 32'(ev_tvalid), 32'h0);
    din = 4'b0000;
    exp_q.push_back(3'b011);
    tick(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
